dmem_arbiter: RTL and testbench

- Owns the data memory (DMEM) port and shares it between two requesters:
  - Port A: the pipeline MEM stage, performing loads and stores.
  - Port B: the program loader / debug requester.
- Sequences each access over a fixed number of memory cycles, returns registered read data, and drives stall_m to the hazard unit while a pipeline access is outstanding.
- Sits between the memory-stage logic and the DMEM instance.

---
 rtl/dmem_arb_pkg.sv | 5 +
 rtl/dmem_arbiter_if.sv | 14 +
 rtl/dmem_grant_sel.sv | 19 +
 rtl/dmem_arbiter.sv | 64 ++++++
 tb/tb_dmem_arbiter.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state and owner encodings for the DMEM arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: pipeline port A, loader/debug port B and the DMEM port
interface dmem_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic a_req, a_we, a_ack, stall_m, b_req, b_we, b_ack, mem_we;
  logic [AW-1:0] a_addr, b_addr, mem_addr;
  logic [DW-1:0] a_wdata, a_rdata, b_wdata, b_rdata, mem_wd, mem_rd;
  modport slave (
    input a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rd,
    output a_ack, a_rdata, stall_m, b_ack, b_rdata, mem_we, mem_addr, mem_wd
  );
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rd,
    input a_ack, a_rdata, stall_m, b_ack, b_rdata, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/dmem_grant_sel.sv
// dmem_grant_sel: A-priority grant, yielding to B after MAX_A_STREAK A grants
module dmem_grant_sel #(parameter int MAX_A_STREAK = 4) (
  input  logic clk,
  input  logic rst,
  input  logic a_req,
  input  logic b_req,
  input  logic grant,
  output logic grant_b
);
  localparam int SW = $clog2(MAX_A_STREAK + 1);
  logic [SW-1:0] a_streak;
  logic full;
  always_comb full = a_streak == SW'(MAX_A_STREAK);
  always_comb grant_b = b_req & (~a_req | full);
  // streak only grows while B is actually being made to wait
  always_ff @(posedge clk or negedge rst)
    if (!rst) a_streak <= '0;
    else if (grant) a_streak <= (grant_b | ~b_req) ? '0 : full ? a_streak : a_streak + 1'b1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one DMEM port between the MEM stage (A) and loader/debug (B)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LAT = 1,
  parameter int MAX_A_STREAK = 4
) (
  input logic clk,
  input logic rst,
  dmem_arbiter_if.slave bus
);
  localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
  state_t state, state_nx;
  owner_t owner;
  logic we_r, grant, grant_b, last, ack_a, ack_b;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wd_r, a_rd, b_rd;
  dmem_grant_sel #(.MAX_A_STREAK(MAX_A_STREAK)) u_sel (
    .clk(clk), .rst(rst), .a_req(bus.a_req), .b_req(bus.b_req), .grant(grant), .grant_b(grant_b)
  );
  always_comb grant = state == IDLE && (bus.a_req || bus.b_req);
  always_comb last = cnt == '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = state == IDLE ? (grant ? ACCESS : IDLE) :
                         state == ACCESS ? (last ? DONE : ACCESS) : IDLE;
  // request fields are captured once at grant; later input changes are ignored
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      owner <= OWN_A;
      we_r <= 1'b0;
      cnt <= '0;
      addr_r <= '0;
      wd_r <= '0;
      a_rd <= '0;
      b_rd <= '0;
    end else begin
      if (grant) begin
        owner <= grant_b ? OWN_B : OWN_A;
        we_r <= grant_b ? bus.b_we : bus.a_we;
        addr_r <= grant_b ? bus.b_addr : bus.a_addr;
        wd_r <= grant_b ? bus.b_wdata : bus.a_wdata;
        cnt <= CW'(LAT - 1);
      end else if (state == ACCESS && !last) cnt <= cnt - 1'b1;
      if (state == ACCESS && last && !we_r && owner == OWN_A) a_rd <= bus.mem_rd;
      if (state == ACCESS && last && !we_r && owner == OWN_B) b_rd <= bus.mem_rd;
    end
  always_comb begin
    ack_a = state == DONE && owner == OWN_A;
    ack_b = state == DONE && owner == OWN_B;
    bus.a_ack = ack_a;
    bus.b_ack = ack_b;
    bus.stall_m = bus.a_req & ~ack_a;
    bus.mem_we = state == ACCESS && last && we_r;
    bus.mem_addr = addr_r;
    bus.mem_wd = wd_r;
    bus.a_rdata = a_rd;
    bus.b_rdata = b_rd;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized two-port traffic against a transaction-level arbitration model
module tb_dmem_arbiter;
  localparam int AW = 32, DW = 32, LAT = 3, MAXS = 4;
  typedef struct {bit port; int cyc; bit we; logic [AW-1:0] addr; logic [DW-1:0] wd, rd;} exp_t;
  typedef struct {bit act; bit we; logic [AW-1:0] addr; logic [DW-1:0] wd;} req_t;
  logic clk = 0, rst = 0, load_mem = 0;
  int cyc = 0, tests = 0, fails = 0;
  int idle_at, streak, a_free, b_free;
  bit mon_en = 0;
  req_t pa, pb;
  exp_t sb[$];
  logic [DW-1:0] dmem[64], ref_mem[64], last_a, last_b;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus();
  dmem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .MAX_A_STREAK(MAXS)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.mem_rd = dmem[bus.mem_addr[7:2]];
  always @(posedge clk)
    if (load_mem) dmem <= ref_mem;
    else if (bus.mem_we) dmem[bus.mem_addr[7:2]] <= bus.mem_wd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_ack"}, bus.a_ack, 0);
    chk({tag, "_b_ack"}, bus.b_ack, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_stall"}, bus.stall_m, 0);
    chk({tag, "_a_rdata"}, bus.a_rdata, 0);
    chk({tag, "_b_rdata"}, bus.b_rdata, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wd"}, bus.mem_wd, 0);
  endtask

  // expected behaviour seen from outside: ack cycle, DMEM window, held read data
  always @(negedge clk) begin : mon
    bit ea, eb, acc;
    if (!rst) begin
      last_a = '0;
      last_b = '0;
    end else if (mon_en) begin
      ea = sb.size() > 0 && sb[0].cyc == cyc && !sb[0].port;
      eb = sb.size() > 0 && sb[0].cyc == cyc && sb[0].port;
      acc = sb.size() > 0 && cyc >= sb[0].cyc - LAT && cyc < sb[0].cyc;
      chk("a_ack", bus.a_ack, ea);
      chk("b_ack", bus.b_ack, eb);
      chk("stall_m", bus.stall_m, bus.a_req & ~ea);
      chk("mem_we", bus.mem_we, acc && sb[0].we && cyc == sb[0].cyc - 1);
      if (acc) chk("mem_addr", bus.mem_addr, sb[0].addr);
      if (acc && sb[0].we) chk("mem_wd", bus.mem_wd, sb[0].wd);
      if (ea && !sb[0].we) last_a = sb[0].rd;
      if (eb && !sb[0].we) last_b = sb[0].rd;
      chk("a_rdata", bus.a_rdata, last_a);
      chk("b_rdata", bus.b_rdata, last_b);
      if (ea || eb) void'(sb.pop_front());
    end
  end

  function automatic req_t rnd_req(input int pct);
    req_t r;
    r.act = $urandom_range(99) < pct;
    r.we = 1'($urandom_range(1));
    r.addr = AW'($urandom_range(63)) << 2;
    r.wd = $urandom;
    return r;
  endfunction

  // one clock of the reference model: release, issue, drive, arbitrate
  task automatic step(input int pa_pct, input int pb_pct);
    bit gb;
    req_t r;
    @(posedge clk);
    #1;
    if (pa.act && a_free == cyc) pa.act = 0;
    if (pb.act && b_free == cyc) pb.act = 0;
    if (!pa.act) begin pa = rnd_req(pa_pct); a_free = -1; end
    if (!pb.act) begin pb = rnd_req(pb_pct); b_free = -1; end
    bus.a_req = pa.act; bus.a_we = pa.we; bus.a_addr = pa.addr; bus.a_wdata = pa.wd;
    bus.b_req = pb.act; bus.b_we = pb.we; bus.b_addr = pb.addr; bus.b_wdata = pb.wd;
    if (idle_at == cyc) begin
      if (pa.act || pb.act) begin
        gb = pb.act && (!pa.act || streak == MAXS);
        streak = (gb || !pb.act) ? 0 : (streak < MAXS ? streak + 1 : MAXS);
        r = gb ? pb : pa;
        sb.push_back('{port: gb, cyc: cyc + LAT + 1, we: r.we, addr: r.addr, wd: r.wd,
                       rd: ref_mem[r.addr[7:2]]});
        if (r.we) ref_mem[r.addr[7:2]] = r.wd;
        if (gb) b_free = cyc + LAT + 2;
        else a_free = cyc + LAT + 2;
        idle_at = cyc + LAT + 2;
      end else idle_at = cyc + 1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (sb.size() > 0 || pa.act || pb.act); i++) step(0, 0);
    chk("drain", sb.size(), 0);
  endtask

  task automatic do_a(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    pa = '{act: 1, we: we, addr: addr, wd: wd};
    a_free = -1;
    drain();
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1;
    pa.act = 0; pb.act = 0;
    a_free = -1; b_free = -1;
    streak = 0;
    idle_at = cyc + 1;
    mon_en = 1;
  endtask

  initial begin
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    ref_mem[16] = 32'hDEADBEEF;
    load_mem = 1;
    repeat (3) @(posedge clk);
    load_mem = 0;
    @(negedge clk);
    chk_zero("reset");
    release_rst();
    // both ports rise together and stay busy: A,A,A,A,B pattern
    repeat (150) step(100, 100);
    drain();
    do_a(0, 'h40, '0);
    do_a(1, 'h80, 32'h12345678);
    do_a(0, 'h80, '0);
    repeat (800) step(40, 40);
    repeat (400) step(80, 15);
    drain();
    // reset in the middle of a store to 0x10
    mon_en = 0;
    @(posedge clk);
    #1;
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 'h10; bus.a_wdata = 32'hA5A55A5A;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    bus.a_req = 0;
    #2;
    chk_zero("abort");
    @(negedge clk);
    chk_zero("abort_hold");
    release_rst();
    chk("abort_mem", dmem[4], ref_mem[4]);
    do_a(0, 'h10, '0);
    repeat (200) step(50, 50);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
